// File: rtl/sd_access_arbiter_pkg.sv
// Shared definitions for the SD access arbiter: FSM encodings, port indices
// and the packed command word held by each request slot.
package sd_access_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sd_cmd_t;

endpackage

// File: rtl/sd_req_slot.sv
// One-deep request latch for a single requester; the slot stays full from
// the accepting edge until the arbiter clears it on leaving RESP.
module sd_req_slot
    import sd_access_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_clear,
    output logic        o_pending,
    output logic        o_sd_ready,
    output sd_cmd_t     o_cmd
);

    logic    r_pending;
    sd_cmd_t r_cmd;

    // Clear wins over a same-cycle request, so a request in RESP is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_cmd     <= '0;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end else if (i_req && !r_pending) begin
            r_pending   <= 1'b1;
            r_cmd.we    <= i_we;
            r_cmd.addr  <= i_addr;
            r_cmd.wdata <= i_wdata;
        end
    end

    assign o_pending  = r_pending;
    assign o_sd_ready = ~r_pending;
    assign o_cmd      = r_cmd;

endmodule

// File: rtl/sd_access_arbiter.sv
// Round-robin sharing of one SD controller between the CPU and the boot
// loader: slot latch, command handshake, completion/timeout, response demux.
module sd_access_arbiter
    import sd_access_arbiter_pkg::*;
#(
    parameter int TIMEOUT_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_sd_ready,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_sd_ready,
    output logic        ld_done,
    output logic [31:0] ld_rdata,
    output logic        ld_err,
    output logic        sd_cmd_valid,
    input  logic        sd_cmd_ready,
    output logic        sd_cmd_we,
    output logic [31:0] sd_cmd_addr,
    output logic [31:0] sd_cmd_wdata,
    input  logic        sd_done,
    input  logic [31:0] sd_rdata
);

    logic [1:0]           r_state;
    logic                 r_grant;
    logic                 r_last_grant;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic                 r_cmd_we;
    logic [31:0]          r_cmd_addr;
    logic [31:0]          r_cmd_wdata;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_we;
    logic [NUM_PORTS-1:0] w_clear;
    logic [NUM_PORTS-1:0] w_pending;
    logic [NUM_PORTS-1:0] w_ready;
    logic [31:0]          w_addr     [NUM_PORTS];
    logic [31:0]          w_wdata    [NUM_PORTS];
    sd_cmd_t              w_slot_cmd [NUM_PORTS];
    sd_cmd_t              w_sel_cmd;
    logic                 w_sel;
    logic                 w_resp;

    assign w_req      = {ld_req, cpu_req};
    assign w_we       = {ld_we, cpu_we};
    assign w_addr[0]  = cpu_addr;
    assign w_addr[1]  = ld_addr;
    assign w_wdata[0] = cpu_wdata;
    assign w_wdata[1] = ld_wdata;
    assign w_resp     = (r_state == ST_RESP);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
            assign w_clear[gi] = w_resp && (int'(r_grant) == gi);

            sd_req_slot u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_req      (w_req[gi]),
                .i_we       (w_we[gi]),
                .i_addr     (w_addr[gi]),
                .i_wdata    (w_wdata[gi]),
                .i_clear    (w_clear[gi]),
                .o_pending  (w_pending[gi]),
                .o_sd_ready (w_ready[gi]),
                .o_cmd      (w_slot_cmd[gi])
            );
        end
    endgenerate

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign w_sel     = (&w_pending) ? ~r_last_grant : w_pending[PORT_LD];
    assign w_sel_cmd = w_slot_cmd[w_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= PORT_CPU;
            r_last_grant <= PORT_LD;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_grant     <= w_sel;
                        r_cmd_we    <= w_sel_cmd.we;
                        r_cmd_addr  <= w_sel_cmd.addr;
                        r_cmd_wdata <= w_sel_cmd.wdata;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sd_cmd_ready) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion arriving on the expiry cycle still counts as success.
                    if (sd_done) begin
                        r_rdata <= sd_rdata;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (&r_cnt) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sd_cmd_valid = (r_state == ST_ISSUE);
    assign sd_cmd_we    = r_cmd_we;
    assign sd_cmd_addr  = r_cmd_addr;
    assign sd_cmd_wdata = r_cmd_wdata;

    assign cpu_sd_ready = w_ready[PORT_CPU];
    assign ld_sd_ready  = w_ready[PORT_LD];

    assign cpu_done  = w_resp && (r_grant == PORT_CPU);
    assign cpu_rdata = cpu_done ? r_rdata : '0;
    assign cpu_err   = cpu_done & r_err;

    assign ld_done   = w_resp && (r_grant == PORT_LD);
    assign ld_rdata  = ld_done ? r_rdata : '0;
    assign ld_err    = ld_done & r_err;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Scoreboard bench for sd_access_arbiter: expected commands and responses are
// queued when requests are driven and consumed as the DUT produces them.
module tb_sd_access_arbiter;

    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_sd_ready, cpu_done, cpu_err;
    logic        ld_sd_ready, ld_done, ld_err;
    logic [31:0] cpu_rdata, ld_rdata;
    logic        sd_cmd_valid, sd_cmd_ready, sd_cmd_we;
    logic [31:0] sd_cmd_addr, sd_cmd_wdata;
    logic        sd_done;
    logic [31:0] sd_rdata;

    logic        resp_done = 1'b0, stray_done = 1'b0;
    logic [31:0] resp_rdata = '0, stray_rdata = '0;
    assign sd_done  = resp_done | stray_done;
    assign sd_rdata = resp_rdata | stray_rdata;

    always #5 clk = ~clk;

    sd_access_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_sd_ready(cpu_sd_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_sd_ready(ld_sd_ready), .ld_done(ld_done), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .sd_cmd_valid(sd_cmd_valid), .sd_cmd_ready(sd_cmd_ready), .sd_cmd_we(sd_cmd_we),
        .sd_cmd_addr(sd_cmd_addr), .sd_cmd_wdata(sd_cmd_wdata),
        .sd_done(sd_done), .sd_rdata(sd_rdata)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    txn_t q_cmd[$];
    txn_t q_rsp[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Controller model: answers a handshake with rsp_base ^ addr after resp_delay cycles (0 = never).
    int          resp_delay = 1;
    logic [31:0] rsp_base   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input bit with_rsp);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.err = err;
        q_cmd.push_back(t);
        if (with_rsp) q_rsp.push_back(t);
    endtask

    task automatic rsp_check(input logic port, input logic [31:0] rdata, input logic err);
        txn_t t;
        if (q_rsp.size() == 0) begin
            check("rsp_unexpected", 64'(1), 64'(0));
            return;
        end
        t = q_rsp.pop_front();
        check("rsp_port", 64'(port), 64'(t.port));
        check("rsp_rdata", 64'(rdata), 64'(t.rdata));
        check("rsp_err", 64'(err), 64'(t.err));
        $display("txn port=%0d we=%0d addr=0x%08h rdata=0x%08h err=%0d", port, t.we, t.addr, rdata, err);
    endtask

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            ld_req = req; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end
    endtask

    // Returns 1 time unit after the edge that samples the request.
    task automatic issue(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        drive_port(port, 1'b1, we, addr, wdata);
        @(posedge clk); #1;
        drive_port(port, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic issue_both(input logic [31:0] c_addr, input logic [31:0] l_addr, input logic [31:0] l_wdata);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, c_addr, '0);
        drive_port(1'b1, 1'b1, 1'b1, l_addr, l_wdata);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_done(input string tag, input logic port, input int max_cyc, output int cyc);
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if ((port == 1'b0 && cpu_done) || (port == 1'b1 && ld_done)) return;
        end
        check(tag, 64'(0), 64'(1));
    endtask

    always begin : responder
        int          d;
        logic [31:0] rd;
        @(negedge clk);
        if (rst_n && sd_cmd_valid && sd_cmd_ready && resp_delay > 0) begin
            d  = resp_delay;
            rd = rsp_base ^ sd_cmd_addr;
            @(posedge clk);
            repeat (d - 1) @(posedge clk);
            #1; resp_done = 1'b1; resp_rdata = rd;
            @(posedge clk);
            #1; resp_done = 1'b0; resp_rdata = '0;
        end
    end

    always @(negedge clk) begin : monitor
        txn_t t;
        if (rst_n) begin
            if (sd_cmd_valid && sd_cmd_ready) begin
                if (q_cmd.size() == 0) begin
                    check("cmd_unexpected", 64'(1), 64'(0));
                end else begin
                    t = q_cmd.pop_front();
                    check("cmd_we", 64'(sd_cmd_we), 64'(t.we));
                    check("cmd_addr", 64'(sd_cmd_addr), 64'(t.addr));
                    check("cmd_wdata", 64'(sd_cmd_wdata), 64'(t.wdata));
                end
            end
            if (cpu_done) rsp_check(1'b0, cpu_rdata, cpu_err);
            else check("cpu_idle_outputs", 64'({cpu_rdata, cpu_err}), 64'(0));
            if (ld_done) rsp_check(1'b1, ld_rdata, ld_err);
            else check("ld_idle_outputs", 64'({ld_rdata, ld_err}), 64'(0));
            check("done_exclusive", 64'(cpu_done & ld_done), 64'(0));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        int k;
        rst_n = 1'b0;
        sd_cmd_ready = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_sd_ready", 64'(cpu_sd_ready), 64'(1));
        check("rst_ld_sd_ready", 64'(ld_sd_ready), 64'(1));
        check("rst_cmd_valid", 64'(sd_cmd_valid), 64'(0));
        check("rst_done", 64'({cpu_done, ld_done}), 64'(0));
        check("rst_cmd_addr", 64'(sd_cmd_addr), 64'(0));
        rst_n = 1'b1;

        // Tie right after reset: CPU first, loader one IDLE cycle after the CPU response.
        resp_delay = 1;
        rsp_base   = 32'h1111_0000;
        expect_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_0100, 1'b0, 1'b1);
        expect_txn(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 32'h1111_0200, 1'b0, 1'b1);
        issue_both(32'h0000_0100, 32'h0000_0200, 32'hCAFE_0001);
        check("tie_ready_low", 64'({cpu_sd_ready, ld_sd_ready}), 64'(0));
        wait_done("tie_cpu_done_timeout", 1'b0, 20, cyc);
        check("tie_cpu_min_latency", 64'(cyc), 64'(4));
        @(negedge clk);
        check("tie_idle_gap_valid", 64'(sd_cmd_valid), 64'(0));
        check("tie_ld_still_pending", 64'(ld_sd_ready), 64'(0));
        @(negedge clk);
        check("tie_ld_issue_valid", 64'(sd_cmd_valid), 64'(1));
        check("tie_ld_issue_addr", 64'(sd_cmd_addr), 64'(32'h0000_0200));
        wait_done("tie_ld_done_timeout", 1'b1, 20, cyc);

        // CPU read answered two cycles after the handshake.
        resp_delay = 2;
        rsp_base   = 32'hDEAD_BEEF ^ 32'h0000_0010;
        expect_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        check("rd_ready_low", 64'(cpu_sd_ready), 64'(0));
        wait_done("rd_done_timeout", 1'b0, 20, cyc);
        check("rd_latency", 64'(cyc), 64'(5));
        check("rd_rdata", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
        check("rd_ready_in_resp", 64'(cpu_sd_ready), 64'(0));
        @(negedge clk);
        check("rd_ready_after_resp", 64'(cpu_sd_ready), 64'(1));
        check("rd_done_one_cycle", 64'(cpu_done), 64'(0));

        // Round robin after a loader grant, plus dropped repeat requests.
        resp_delay = 1;
        rsp_base   = 32'h0F0F_0000;
        expect_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0F0F_0300, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        wait_done("rr_ld1_timeout", 1'b1, 20, cyc);
        expect_txn(1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h0F0F_0400, 1'b0, 1'b1);
        expect_txn(1'b1, 1'b1, 32'h0000_0500, 32'h5555_0005, 32'h0F0F_0500, 1'b0, 1'b1);
        issue_both(32'h0000_0400, 32'h0000_0500, 32'h5555_0005);
        issue(1'b1, 1'b1, 32'h0000_0BAD, 32'h0000_0BAD);
        wait_done("rr_cpu_timeout", 1'b0, 20, cyc);
        check("rr_ld_ready_while_pending", 64'(ld_sd_ready), 64'(0));
        wait_done("rr_ld2_timeout", 1'b1, 20, cyc);
        drive_port(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
        @(posedge clk); #1;
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        check("rr_resp_req_dropped", 64'(ld_sd_ready), 64'(1));
        repeat (6) @(negedge clk);
        check("rr_no_cmd_after_drop", 64'(sd_cmd_valid), 64'(0));
        expect_txn(1'b1, 1'b0, 32'h0000_0700, 32'h0, 32'h0F0F_0700, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_0700, 32'h0);
        wait_done("rr_ld3_timeout", 1'b1, 20, cyc);
        expect_txn(1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'h0F0F_0800, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        wait_done("rr_ld4_timeout", 1'b1, 20, cyc);
        check("rr_req_after_resp_latency", 64'(cyc), 64'(4));

        // Timeout with no completion, then a completion on the expiry cycle.
        resp_delay = 0;
        expect_txn(1'b0, 1'b0, 32'h0000_0900, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 1'b0, 32'h0000_0900, 32'h0);
        wait_done("to_done_timeout", 1'b0, 40, cyc);
        check("to_latency_range", 64'(cyc >= 18 && cyc <= 19), 64'(1));
        check("to_err", 64'(cpu_err), 64'(1));
        check("to_rdata", 64'(cpu_rdata), 64'(0));
        resp_delay = 16;
        rsp_base   = 32'h7777_0000;
        expect_txn(1'b0, 1'b0, 32'h0000_0A00, 32'h0, 32'h7777_0A00, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 32'h0000_0A00, 32'h0);
        wait_done("to_coincide_timeout", 1'b0, 40, cyc);
        check("to_coincide_latency", 64'(cyc), 64'(19));
        check("to_coincide_err", 64'(cpu_err), 64'(0));

        // Backpressure: command held while ready is low, stray completion ignored.
        @(posedge clk); #1;
        sd_cmd_ready = 1'b0;
        resp_delay   = 2;
        rsp_base     = 32'h5A5A_0000;
        expect_txn(1'b1, 1'b1, 32'h0000_0B00, 32'h1234_5678, 32'h5A5A_0B00, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 32'h0000_0B00, 32'h1234_5678);
        k = 0;
        while (!sd_cmd_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", 64'(sd_cmd_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(sd_cmd_valid), 64'(1));
            check("bp_we", 64'(sd_cmd_we), 64'(1));
            check("bp_addr", 64'(sd_cmd_addr), 64'(32'h0000_0B00));
            check("bp_wdata", 64'(sd_cmd_wdata), 64'(32'h1234_5678));
            @(posedge clk); #1;
            stray_done  = (i == 1);
            stray_rdata = (i == 1) ? 32'hBADB_AD00 : 32'h0;
            if (i == 4) sd_cmd_ready = 1'b1;
            @(negedge clk);
        end
        wait_done("bp_done_timeout", 1'b1, 20, cyc);

        // Reset in WAIT: everything returns to idle and nothing is replayed.
        resp_delay = 0;
        expect_txn(1'b0, 1'b0, 32'h0000_0C00, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 32'h0000_0C00, 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_cmd_valid", 64'(sd_cmd_valid), 64'(0));
        check("mrst_cmd_fields", 64'({sd_cmd_we, sd_cmd_addr}), 64'(0));
        check("mrst_cmd_wdata", 64'(sd_cmd_wdata), 64'(0));
        check("mrst_done_err", 64'({cpu_done, ld_done, cpu_err, ld_err}), 64'(0));
        check("mrst_rdata", 64'({cpu_rdata, ld_rdata}), 64'(0));
        check("mrst_sd_ready", 64'({cpu_sd_ready, ld_sd_ready}), 64'(2'b11));
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        resp_delay = 1;
        rsp_base   = 32'h3C3C_0000;
        expect_txn(1'b1, 1'b0, 32'h0000_0D00, 32'h0, 32'h3C3C_0D00, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_0D00, 32'h0);
        wait_done("mrst_after_done_timeout", 1'b1, 20, cyc);
        check("mrst_after_latency", 64'(cyc), 64'(4));

        repeat (5) @(negedge clk);
        check("q_cmd_drained", 64'(q_cmd.size()), 64'(0));
        check("q_rsp_drained", 64'(q_rsp.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
